// File: rtl/gpr_pkg.sv
// Shared GPR constants and types: register count/width, index and word types,
// and the dump-reader state encoding.
package gpr_pkg;

  localparam int NREG  = 32;
  localparam int XLEN  = 32;
  localparam int IDX_W = $clog2(NREG);

  typedef logic [IDX_W-1:0] gpr_idx_t;
  typedef logic [XLEN-1:0]  gpr_word_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    SUM
  } dump_state_e;

  localparam gpr_idx_t LAST_IDX = gpr_idx_t'(NREG - 1);

endpackage

// File: rtl/gpr_dump_reader_if.sv
// Beat stream from the GPR dump reader to a debug/trace sink (valid/ready).
interface gpr_dump_reader_if;
  import gpr_pkg::*;

  logic      out_valid;
  logic      out_ready;
  gpr_idx_t  out_idx;
  gpr_word_t out_data;
  logic      out_last;

  modport master (
    output out_valid,
    output out_idx,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/gpr_dump_reader.sv
// Walks GPR read port 1 over every register on a start pulse and streams (index, value) beats.
// Define GPR_DUMP_CHECKSUM_EN to append a trailing XOR-checksum beat to each dump.
module gpr_dump_reader
  import gpr_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output gpr_idx_t                  Ra,
  input  gpr_word_t                 busA,
  gpr_dump_reader_if.master         out
);

  dump_state_e state_q, state_d;
  gpr_idx_t    idx_q, idx_d;
  gpr_idx_t    out_idx_q, out_idx_d;
  gpr_word_t   out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        done_q, done_d;
  logic        handshake;
`ifdef GPR_DUMP_CHECKSUM_EN
  gpr_word_t   sum_q, sum_d;
`endif

  assign handshake = out.out_valid && out.out_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    done_d     = 1'b0;
    Ra         = '0;
`ifdef GPR_DUMP_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          idx_d   = '0;
`ifdef GPR_DUMP_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end

      READ: begin
        // busA is combinational from Ra, so the value is captured in the same cycle.
        Ra         = idx_q;
        out_data_d = busA;
        out_idx_d  = idx_q;
`ifdef GPR_DUMP_CHECKSUM_EN
        out_last_d = 1'b0;
        sum_d      = sum_q ^ busA;
`else
        out_last_d = (idx_q == LAST_IDX);
`endif
        state_d    = SEND;
      end

      SEND: begin
        if (handshake) begin
          // Terminal compare comes before the increment, so idx never wraps.
          if (idx_q == LAST_IDX) begin
`ifdef GPR_DUMP_CHECKSUM_EN
            state_d    = SUM;
            out_idx_d  = '0;
            out_data_d = sum_q;
            out_last_d = 1'b1;
`else
            state_d    = IDLE;
            done_d     = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + gpr_idx_t'(1);
            state_d = READ;
          end
        end
      end

      SUM: begin
        if (handshake) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      done_q     <= done_d;
    end
  end

`ifdef GPR_DUMP_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  // out_valid, out_last and busy are decoded from state, so reset clears them asynchronously.
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign out.out_valid = (state_q == SEND) || (state_q == SUM);
  assign out.out_idx   = out_idx_q;
  assign out.out_data  = out_data_q;
  assign out.out_last  = out_last_q && out.out_valid;

endmodule

// File: tb/tb_gpr_dump_reader.sv
// Scoreboard bench for gpr_dump_reader: a GPR model sits behind Ra/busA, expected beats are
// queued when a dump is launched and a negedge monitor pops and compares on each handshake.
module tb_gpr_dump_reader;
  import gpr_pkg::*;

  typedef struct packed {
    gpr_idx_t  idx;
    gpr_word_t data;
    logic      last;
  } beat_t;

  logic      clk   = 1'b0;
  logic      rst_n = 1'b0;
  logic      start = 1'b0;
  logic      busy;
  logic      done;
  gpr_idx_t  ra;
  gpr_word_t bus_a;

  gpr_word_t gpr [NREG];
  gpr_word_t img [NREG];

  gpr_dump_reader_if dif ();

  gpr_dump_reader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .Ra    (ra),
    .busA  (bus_a),
    .out   (dif)
  );

  assign bus_a = gpr[ra];

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  int    first_valid_cyc = 0;
  int    last_hs_cyc = 0;
  int    beats_seen = 0;
  int    done_cnt = 0;
  bit    seen_valid = 1'b0;
  bit    timing_mode = 1'b0;
  bit    exp_done = 1'b0;
  bit    prev_stall = 1'b0;
  beat_t held;
  beat_t sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: compares every accepted beat against the scoreboard and checks stall stability.
  always @(negedge clk) begin
    beat_t cur;
    beat_t exp;
    cur = '{idx: dif.out_idx, data: dif.out_data, last: dif.out_last};
    if (!rst_n) begin
      prev_stall = 1'b0;
      exp_done   = 1'b0;
    end else begin
      if (exp_done || done) check("done_pulse", 64'(done), 64'(exp_done));
      if (done) done_cnt++;
      exp_done = 1'b0;
      if (prev_stall) begin
        check("stall_valid_held", 64'(dif.out_valid), 64'd1);
        check("stall_beat_held", 64'(cur), 64'(held));
      end
      if (dif.out_valid && !seen_valid) begin
        seen_valid      = 1'b1;
        first_valid_cyc = cyc;
      end
      if (dif.out_valid && dif.out_ready) begin
        if (sb_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          exp = sb_q.pop_front();
          check("beat_idx", 64'(cur.idx), 64'(exp.idx));
          check("beat_data", 64'(cur.data), 64'(exp.data));
          check("beat_last", 64'(cur.last), 64'(exp.last));
          if (timing_mode && beats_seen > 0) check("beat_spacing", 64'(cyc - last_hs_cyc), 64'd2);
          last_hs_cyc = cyc;
          beats_seen++;
          if (exp.last) exp_done = 1'b1;
        end
      end
      prev_stall = dif.out_valid && !dif.out_ready;
      held       = cur;
    end
  end

  task automatic push_dump();
    beat_t     b;
    gpr_word_t sum;
    sum = '0;
    for (int i = 0; i < NREG; i++) begin
      b.idx  = gpr_idx_t'(i);
      b.data = img[i];
`ifdef GPR_DUMP_CHECKSUM_EN
      b.last = 1'b0;
`else
      b.last = (i == NREG - 1);
`endif
      sum = sum ^ img[i];
      sb_q.push_back(b);
    end
`ifdef GPR_DUMP_CHECKSUM_EN
    b.idx  = '0;
    b.data = sum;
    b.last = 1'b1;
    sb_q.push_back(b);
`endif
  endtask

  task automatic load_base();
    for (int i = 0; i < NREG; i++) gpr[i] = '0;
    gpr[1]  = 32'h1111_1111;
    gpr[2]  = 32'h2222_2222;
    gpr[31] = 32'hDEAD_BEEF;
    for (int i = 0; i < NREG; i++) img[i] = gpr[i];
  endtask

  task automatic start_dump();
    @(posedge clk); #1;
    push_dump();
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_until_idle(input bit rand_ready, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      if (rand_ready) dif.out_ready = 1'($urandom_range(0, 1));
      n++;
    end while ((busy || sb_q.size() != 0) && n < budget);
    if (busy || sb_q.size() != 0) fail_now("dump_timeout");
    dif.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Samples #1 after posedge so inputs changed here are settled before the monitor's negedge.
  task automatic wait_beat(input bit want_last, input gpr_idx_t idx, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(dif.out_valid && (want_last ? dif.out_last : (dif.out_idx == idx))) && n < budget);
    if (n >= budget) fail_now("wait_beat_timeout");
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_done"},  64'(done), 64'd0);
    check({tag, "_valid"}, 64'(dif.out_valid), 64'd0);
    check({tag, "_last"},  64'(dif.out_last), 64'd0);
    check({tag, "_ra"},    64'(ra), 64'd0);
    check({tag, "_idx"},   64'(dif.out_idx), 64'd0);
    check({tag, "_data"},  64'(dif.out_data), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    dif.out_ready = 1'b1;
    load_base();

    // 1: reset state, then a full dump with an always-ready sink.
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    timing_mode = 1'b1;
    seen_valid  = 1'b0;
    beats_seen  = 0;
    d0 = done_cnt;
    start_dump();
    run_until_idle(1'b0, 200);
    check("first_valid_latency", 64'(first_valid_cyc - start_cyc), 64'd2);
    check("done_count_s1", 64'(done_cnt - d0), 64'd1);
    check("busy_after_s1", 64'(busy), 64'd0);
    timing_mode = 1'b0;

    // 2: pseudo-random backpressure.
    d0 = done_cnt;
    dif.out_ready = 1'b0;
    start_dump();
    run_until_idle(1'b1, 2000);
    check("done_count_s2", 64'(done_cnt - d0), 64'd1);

    // 3: start mid-dump is ignored; start coincident with done launches a second dump.
    d0 = done_cnt;
    start_dump();
    wait_beat(1'b0, gpr_idx_t'(5), 200);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_beat(1'b1, '0, 200);
    @(posedge clk); #1;
    check("done_coincident", 64'(done), 64'd1);
    start = 1'b1;
    push_dump();
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_second_dump", 64'(busy), 64'd1);
    run_until_idle(1'b0, 300);
    check("done_count_s3", 64'(done_cnt - d0), 64'd2);

    // 4: reset while stalled on beat 10, then a clean dump.
    start_dump();
    wait_beat(1'b0, gpr_idx_t'(10), 200);
    dif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    sb_q.delete();
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    check("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
    rst_n = 1'b1;
    dif.out_ready = 1'b1;
    d0 = done_cnt;
    start_dump();
    run_until_idle(1'b0, 200);
    check("done_count_s4", 64'(done_cnt - d0), 64'd1);

    // 5: x2 is written during the beat-1 handshake cycle, so beat 2 carries the new value.
    img[2] = 32'h0000_ABCD;
    start_dump();
    wait_beat(1'b0, gpr_idx_t'(1), 200);
    gpr[2] = 32'h0000_ABCD;
    run_until_idle(1'b0, 200);
    load_base();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
